matrix_pingpong_mem: RTL and testbench

//  Bank-rotating successor to the A/B/C matrix operand memories. It holds NBANK complete matrix

---
 rtl/matrix_pingpong_mem.sv | 188 ++++++++++++++++++
 tb/tb_matrix_pingpong_mem.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_pingpong_mem.sv
// -----------------------------------------------------------------------------
// matrix_pingpong_mem
//
// Purpose:
//   Bank-rotating store for matrix operands (A, B) and results (C). NBANK
//   complete matrix sets are kept. The user fills one set, the engine computes
//   on another and the user drains C from a third. Each bank carries its own
//   ownership FSM (EMPTY -> READY -> BUSY -> DONE -> EMPTY) so a bank is never
//   overwritten while another party still owns it.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   usr_wr/usr_sel/usr_row/usr_din   write an A (sel=0) or B (sel=1) row into
//                                    the fill bank
//   usr_commit, usr_ready      hand fill bank to the engine / fill bank EMPTY
//   mat_start, mat_valid       engine claims exec bank / exec bank READY
//   mat_rd, mat_row            read A and B row of exec bank (1-cycle latency)
//   mat_a_dout, mat_b_dout     registered A/B read data
//   mat_c_wr, mat_c_din        write C row mat_row of exec bank
//   mat_done                   engine finished, exec bank goes DONE
//   c_valid                    drain bank DONE
//   usr_c_rd, usr_c_row        read C row of drain bank (1-cycle latency)
//   usr_c_dout                 registered C read data
//   usr_c_rel                  release drain bank back to EMPTY
//   cmd_err                    1-cycle pulse after any ignored command
//   dbg_state                  per-bank state, 2 bits per bank (bank b at
//                              [2b+1:2b]); 0=EMPTY 1=READY 2=BUSY 3=DONE
//
// Handshake semantics: each status output (usr_ready, mat_valid, c_valid) is
// a combinational view of the bank selected by the matching pointer. A
// command is accepted only when that bank is in the state that owns the
// command on that cycle; otherwise it has no effect besides cmd_err.
// -----------------------------------------------------------------------------
module matrix_pingpong_mem #(
   parameter  int N       = 6,
   parameter  int WIDTH   = 16,
   parameter  int M_WIDTH = 2*WIDTH+N-1,
   parameter  int NBANK   = 2,
   localparam int ROW_W   = $clog2(N),
   localparam int BANK_W  = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   usr_wr,
   input  logic                   usr_sel,
   input  logic [ROW_W-1:0]       usr_row,
   input  logic [N*WIDTH-1:0]     usr_din,
   input  logic                   usr_commit,
   output logic                   usr_ready,
   input  logic                   mat_start,
   output logic                   mat_valid,
   input  logic                   mat_rd,
   input  logic [ROW_W-1:0]       mat_row,
   output logic [N*WIDTH-1:0]     mat_a_dout,
   output logic [N*WIDTH-1:0]     mat_b_dout,
   input  logic                   mat_c_wr,
   input  logic [N*M_WIDTH-1:0]   mat_c_din,
   input  logic                   mat_done,
   output logic                   c_valid,
   input  logic                   usr_c_rd,
   input  logic [ROW_W-1:0]       usr_c_row,
   output logic [N*M_WIDTH-1:0]   usr_c_dout,
   input  logic                   usr_c_rel,
   output logic                   cmd_err,
   output logic [2*NBANK-1:0]     dbg_state
);

   localparam int ADDR_W = BANK_W + ROW_W;
   localparam int DEPTH  = NBANK * (2**ROW_W);
   // Row bound kept one bit wider than a row index so N = 2**ROW_W works too.
   localparam logic [ROW_W:0] N_ROWS = (ROW_W+1)'(N);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_READY = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } bank_state_t;

   bank_state_t       state_q [NBANK];
   bank_state_t       state_d [NBANK];
   logic [BANK_W-1:0] fill_ptr, exec_ptr, drain_ptr;

   logic [N*WIDTH-1:0]   mem_a [DEPTH];
   logic [N*WIDTH-1:0]   mem_b [DEPTH];
   logic [N*M_WIDTH-1:0] mem_c [DEPTH];

   logic wr_ok, commit_ok, start_ok, rd_ok, cwr_ok, done_ok, crd_ok, rel_ok;
   logic err_d;
   logic usr_row_ok, mat_row_ok, c_row_ok;
   logic fill_empty, exec_ready, exec_busy, drain_done;

   function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
      if (NBANK == 1) return '0;
      return p + BANK_W'(1);
   endfunction

   function automatic logic [ADDR_W-1:0] phys(input logic [BANK_W-1:0] b,
                                              input logic [ROW_W-1:0]  r);
      return {b, r};
   endfunction

   // Acceptance decode, all from the current-cycle bank states.
   always_comb begin
      fill_empty = (state_q[fill_ptr]  == ST_EMPTY);
      exec_ready = (state_q[exec_ptr]  == ST_READY);
      exec_busy  = (state_q[exec_ptr]  == ST_BUSY);
      drain_done = (state_q[drain_ptr] == ST_DONE);

      usr_row_ok = ({1'b0, usr_row}   < N_ROWS);
      mat_row_ok = ({1'b0, mat_row}   < N_ROWS);
      c_row_ok   = ({1'b0, usr_c_row} < N_ROWS);

      wr_ok     = usr_wr     && fill_empty && usr_row_ok;
      commit_ok = usr_commit && fill_empty;
      start_ok  = mat_start  && exec_ready;
      rd_ok     = mat_rd     && exec_busy  && mat_row_ok;
      cwr_ok    = mat_c_wr   && exec_busy  && mat_row_ok;
      done_ok   = mat_done   && exec_busy;
      crd_ok    = usr_c_rd   && drain_done && c_row_ok;
      rel_ok    = usr_c_rel  && drain_done;

      err_d = (usr_wr     && !wr_ok)     || (usr_commit && !commit_ok) ||
              (mat_start  && !start_ok)  || (mat_rd     && !rd_ok)     ||
              (mat_c_wr   && !cwr_ok)    || (mat_done   && !done_ok)   ||
              (usr_c_rd   && !crd_ok)    || (usr_c_rel  && !rel_ok);
   end

   // Next-state for every bank. Each transition requires a distinct current
   // state, so at most one of them can hit a given bank in one cycle even when
   // pointers coincide (NBANK=1).
   always_comb begin
      for (int b = 0; b < NBANK; b++) state_d[b] = state_q[b];
      if (commit_ok) state_d[fill_ptr]  = ST_READY;
      if (start_ok)  state_d[exec_ptr]  = ST_BUSY;
      if (done_ok)   state_d[exec_ptr]  = ST_DONE;
      if (rel_ok)    state_d[drain_ptr] = ST_EMPTY;
   end

   always_comb begin
      dbg_state = '0;
      for (int b = 0; b < NBANK; b++) dbg_state[2*b +: 2] = state_q[b];
   end

   assign usr_ready = fill_empty;
   assign mat_valid = exec_ready;
   assign c_valid   = drain_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < NBANK; b++) state_q[b] <= ST_EMPTY;
         fill_ptr  <= '0;
         exec_ptr  <= '0;
         drain_ptr <= '0;
         cmd_err   <= 1'b0;
      end else begin
         for (int b = 0; b < NBANK; b++) state_q[b] <= state_d[b];
         if (commit_ok) fill_ptr  <= next_ptr(fill_ptr);
         if (done_ok)   exec_ptr  <= next_ptr(exec_ptr);
         if (rel_ok)    drain_ptr <= next_ptr(drain_ptr);
         cmd_err <= err_d;
      end
   end

   // RAM write ports. Contents survive reset; a write in a reset cycle is
   // discarded along with the rest of the in-flight work.
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok && !usr_sel) mem_a[phys(fill_ptr, usr_row)] <= usr_din;
      if (rst_n && wr_ok &&  usr_sel) mem_b[phys(fill_ptr, usr_row)] <= usr_din;
      if (rst_n && cwr_ok)            mem_c[phys(exec_ptr, mat_row)] <= mat_c_din;
   end

   // Registered read ports; hold their value unless a read is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mat_a_dout <= '0;
         mat_b_dout <= '0;
         usr_c_dout <= '0;
      end else begin
         if (rd_ok) begin
            mat_a_dout <= mem_a[phys(exec_ptr, mat_row)];
            mat_b_dout <= mem_b[phys(exec_ptr, mat_row)];
         end
         if (crd_ok) usr_c_dout <= mem_c[phys(drain_ptr, usr_c_row)];
      end
   end

endmodule

// File: tb/tb_matrix_pingpong_mem.sv
// -----------------------------------------------------------------------------
// tb_matrix_pingpong_mem
//
// Bench for matrix_pingpong_mem (N=6, WIDTH=16, NBANK=2). A behavioural model
// keeps bank ownership as small integers, pointers as integers advanced
// modulo NBANK, and RAM contents as per-bank row arrays. Every clock the DUT
// outputs are compared against the model; directed scenarios add literal
// expectations that pin the model, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_matrix_pingpong_mem;

   localparam int N     = 6;
   localparam int WIDTH = 16;
   localparam int MW    = 2*WIDTH+N-1;
   localparam int NBANK = 2;
   localparam int ROW_W = 3;
   localparam int AW    = N*WIDTH;
   localparam int CW    = N*MW;

   localparam int S_EMPTY = 0;
   localparam int S_READY = 1;
   localparam int S_BUSY  = 2;
   localparam int S_DONE  = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic             usr_wr, usr_sel, usr_commit, usr_ready;
   logic [ROW_W-1:0] usr_row, mat_row, usr_c_row;
   logic [AW-1:0]    usr_din, mat_a_dout, mat_b_dout;
   logic             mat_start, mat_valid, mat_rd, mat_c_wr, mat_done;
   logic [CW-1:0]    mat_c_din, usr_c_dout;
   logic             c_valid, usr_c_rd, usr_c_rel, cmd_err;
   logic [2*NBANK-1:0] dbg_state;

   matrix_pingpong_mem #(.N(N), .WIDTH(WIDTH), .M_WIDTH(MW), .NBANK(NBANK)) dut (
      .clk(clk), .rst_n(rst_n),
      .usr_wr(usr_wr), .usr_sel(usr_sel), .usr_row(usr_row), .usr_din(usr_din),
      .usr_commit(usr_commit), .usr_ready(usr_ready),
      .mat_start(mat_start), .mat_valid(mat_valid),
      .mat_rd(mat_rd), .mat_row(mat_row),
      .mat_a_dout(mat_a_dout), .mat_b_dout(mat_b_dout),
      .mat_c_wr(mat_c_wr), .mat_c_din(mat_c_din), .mat_done(mat_done),
      .c_valid(c_valid), .usr_c_rd(usr_c_rd), .usr_c_row(usr_c_row),
      .usr_c_dout(usr_c_dout), .usr_c_rel(usr_c_rel),
      .cmd_err(cmd_err), .dbg_state(dbg_state)
   );

   // ---------------- behavioural model ----------------
   int          mst [NBANK];
   int          fp, ep, dp;
   logic [AW-1:0] ma [NBANK][N];
   logic [AW-1:0] mb [NBANK][N];
   logic [CW-1:0] mc [NBANK][N];
   bit          wa [NBANK][N];
   bit          wb [NBANK][N];
   bit          wc [NBANK][N];
   logic [AW-1:0] ea, eb;
   logic [CW-1:0] ec;
   bit          ka, kb, kc, eerr;

   int checks = 0;
   int errors = 0;

   task automatic model_step();
      bit a_wr, a_cm, a_st, a_rd, a_cw, a_dn, a_cr, a_rl;
      int fs, es, ds, ur, mr, cr;
      if (!rst_n) begin
         for (int b = 0; b < NBANK; b++) mst[b] = S_EMPTY;
         fp = 0; ep = 0; dp = 0;
         ea = '0; eb = '0; ec = '0;
         ka = 1; kb = 1; kc = 1;
         eerr = 0;
         return;
      end
      fs = mst[fp]; es = mst[ep]; ds = mst[dp];
      ur = int'(usr_row); mr = int'(mat_row); cr = int'(usr_c_row);
      a_wr = usr_wr     && fs == S_EMPTY && ur < N;
      a_cm = usr_commit && fs == S_EMPTY;
      a_st = mat_start  && es == S_READY;
      a_rd = mat_rd     && es == S_BUSY && mr < N;
      a_cw = mat_c_wr   && es == S_BUSY && mr < N;
      a_dn = mat_done   && es == S_BUSY;
      a_cr = usr_c_rd   && ds == S_DONE && cr < N;
      a_rl = usr_c_rel  && ds == S_DONE;
      eerr = (usr_wr && !a_wr) || (usr_commit && !a_cm) || (mat_start && !a_st) ||
             (mat_rd && !a_rd) || (mat_c_wr && !a_cw) || (mat_done && !a_dn) ||
             (usr_c_rd && !a_cr) || (usr_c_rel && !a_rl);
      if (a_rd) begin
         ea = ma[ep][mr]; ka = wa[ep][mr];
         eb = mb[ep][mr]; kb = wb[ep][mr];
      end
      if (a_cr) begin
         ec = mc[dp][cr]; kc = wc[dp][cr];
      end
      if (a_wr && !usr_sel) begin ma[fp][ur] = usr_din; wa[fp][ur] = 1; end
      if (a_wr &&  usr_sel) begin mb[fp][ur] = usr_din; wb[fp][ur] = 1; end
      if (a_cw)             begin mc[ep][mr] = mat_c_din; wc[ep][mr] = 1; end
      if (a_cm) begin mst[fp] = S_READY; fp = (fp + 1) % NBANK; end
      if (a_st) mst[ep] = S_BUSY;
      if (a_dn) begin mst[ep] = S_DONE;  ep = (ep + 1) % NBANK; end
      if (a_rl) begin mst[dp] = S_EMPTY; dp = (dp + 1) % NBANK; end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic compare_all();
      logic [2*NBANK-1:0] es;
      es = '0;
      for (int b = 0; b < NBANK; b++) es[2*b +: 2] = 2'(mst[b]);
      chk("usr_ready", 256'(usr_ready), 256'(mst[fp] == S_EMPTY));
      chk("mat_valid", 256'(mat_valid), 256'(mst[ep] == S_READY));
      chk("c_valid",   256'(c_valid),   256'(mst[dp] == S_DONE));
      chk("cmd_err",   256'(cmd_err),   256'(eerr));
      chk("dbg_state", 256'(dbg_state), 256'(es));
      if (ka) chk("mat_a_dout", 256'(mat_a_dout), 256'(ea));
      if (kb) chk("mat_b_dout", 256'(mat_b_dout), 256'(eb));
      if (kc) chk("usr_c_dout", 256'(usr_c_dout), 256'(ec));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      rst_n = 1'b1;
      usr_wr = 0; usr_sel = 0; usr_row = '0; usr_din = '0; usr_commit = 0;
      mat_start = 0; mat_rd = 0; mat_row = '0; mat_c_wr = 0; mat_c_din = '0; mat_done = 0;
      usr_c_rd = 0; usr_c_row = '0; usr_c_rel = 0;
   endtask

   function automatic logic [AW-1:0] rep_a(input logic [WIDTH-1:0] v);
      logic [AW-1:0] r;
      for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = v;
      return r;
   endfunction

   function automatic logic [CW-1:0] rep_c(input logic [MW-1:0] v);
      logic [CW-1:0] r;
      for (int i = 0; i < N; i++) r[i*MW +: MW] = v;
      return r;
   endfunction

   task automatic do_reset();
      idle(); rst_n = 1'b0; tick(); idle();
   endtask
   task automatic do_wr(input bit sel, input int row, input logic [AW-1:0] d);
      usr_wr = 1; usr_sel = sel; usr_row = 3'(row); usr_din = d; tick(); idle();
   endtask
   task automatic do_commit();  usr_commit = 1; tick(); idle(); endtask
   task automatic do_start();   mat_start = 1;  tick(); idle(); endtask
   task automatic do_done();    mat_done = 1;   tick(); idle(); endtask
   task automatic do_rel();     usr_c_rel = 1;  tick(); idle(); endtask
   task automatic do_rd(input int row);
      mat_rd = 1; mat_row = 3'(row); tick(); idle();
   endtask
   task automatic do_cwr(input int row, input logic [CW-1:0] d);
      mat_c_wr = 1; mat_row = 3'(row); mat_c_din = d; tick(); idle();
   endtask
   task automatic do_crd(input int row);
      usr_c_rd = 1; usr_c_row = 3'(row); tick(); idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [255:0] rnd;
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_usr_ready", 256'(usr_ready), 256'(1));
      chk("rst_mat_valid", 256'(mat_valid), 256'(0));
      chk("rst_c_valid",   256'(c_valid),   256'(0));
      chk("rst_a_dout",    256'(mat_a_dout), 256'(0));
      idle();

      // Fill bank0 with A=row, B=0x10+row, read row 3 back through the engine.
      for (int r = 0; r < N; r++) begin
         do_wr(0, r, rep_a(16'(r)));
         do_wr(1, r, rep_a(16'(16 + r)));
      end
      do_commit();
      chk("t1_mat_valid", 256'(mat_valid), 256'(1));
      do_start();
      do_rd(3);
      chk("t1_a_row3", 256'(mat_a_dout), 256'(rep_a(16'h0003)));
      chk("t1_b_row3", 256'(mat_b_dout), 256'(rep_a(16'h0013)));

      // Overlap: fill bank1 while bank0 is BUSY.
      for (int r = 0; r < N; r++) begin
         do_wr(0, r, rep_a(16'(256 + r)));
         do_wr(1, r, rep_a(16'(512 + r)));
      end
      do_commit();
      chk("t2_usr_ready", 256'(usr_ready), 256'(0));
      do_cwr(5, rep_c(37'h0ABC));
      do_done();
      chk("t2_mat_valid", 256'(mat_valid), 256'(1));
      chk("t2_c_valid",   256'(c_valid),   256'(1));
      do_start();
      do_rd(0);
      chk("t2_a_bank1", 256'(mat_a_dout), 256'(rep_a(16'h0100)));

      // Drain C from bank0 and release it.
      do_crd(5);
      chk("t3_c_row5", 256'(usr_c_dout), 256'(rep_c(37'h0ABC)));
      do_rel();
      chk("t3_c_valid",   256'(c_valid),   256'(0));
      chk("t3_usr_ready", 256'(usr_ready), 256'(1));

      // Illegal commands.
      do_commit();
      chk("t4_usr_ready", 256'(usr_ready), 256'(0));
      do_wr(0, 0, rep_a(16'hDEAD));
      chk("t4_err_wr_busy", 256'(cmd_err), 256'(1));
      tick();
      chk("t4_err_clear", 256'(cmd_err), 256'(0));
      do_done();
      do_rd(1);
      chk("t4_err_rd_ready", 256'(cmd_err), 256'(1));
      chk("t4_a_hold", 256'(mat_a_dout), 256'(rep_a(16'h0100)));
      do_rel();
      chk("t4_usr_ready2", 256'(usr_ready), 256'(1));
      do_wr(0, 7, rep_a(16'hBEEF));
      chk("t4_err_row7", 256'(cmd_err), 256'(1));

      // Same-cycle write+commit, and C write+done.
      usr_wr = 1; usr_sel = 0; usr_row = 3'd2; usr_din = rep_a(16'h5A5A); usr_commit = 1;
      tick(); idle();
      do_start();
      mat_c_wr = 1; mat_row = 3'd1; mat_c_din = rep_c(37'h1234); mat_done = 1;
      tick(); idle();
      chk("t5_c_valid", 256'(c_valid), 256'(1));
      do_crd(1);
      chk("t5_c_row1", 256'(usr_c_dout), 256'(rep_c(37'h1234)));
      do_start();
      do_rd(2);
      chk("t5_a_row2", 256'(mat_a_dout), 256'(rep_a(16'h5A5A)));

      // Reset with bank0 BUSY and bank1 READY.
      do_reset();
      do_commit();
      do_start();
      do_commit();
      do_rd(3);
      do_reset();
      chk("t6_usr_ready", 256'(usr_ready), 256'(1));
      chk("t6_mat_valid", 256'(mat_valid), 256'(0));
      chk("t6_c_valid",   256'(c_valid),   256'(0));
      chk("t6_a_dout",    256'(mat_a_dout), 256'(0));
      chk("t6_b_dout",    256'(mat_b_dout), 256'(0));
      chk("t6_c_dout",    256'(usr_c_dout), 256'(0));

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         idle();
         rst_n      = ($urandom_range(0, 299) != 0);
         usr_wr     = ($urandom_range(0, 1) == 1);
         usr_sel    = 1'($urandom_range(0, 1));
         usr_row    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         usr_din    = {$urandom, $urandom, $urandom};
         usr_commit = ($urandom_range(0, 5) == 0);
         mat_start  = ($urandom_range(0, 2) == 0);
         mat_rd     = ($urandom_range(0, 1) == 1);
         mat_row    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         mat_c_wr   = ($urandom_range(0, 1) == 1);
         rnd        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         mat_c_din  = rnd[CW-1:0];
         mat_done   = ($urandom_range(0, 5) == 0);
         usr_c_rd   = ($urandom_range(0, 1) == 1);
         usr_c_row  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         usr_c_rel  = ($urandom_range(0, 5) == 0);
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
